// File: rtl/fifo_sync_fwft_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants,
// pointer-width helper and the registered status-flag bundle.
package fifo_sync_fwft_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int FIFO_MODE_FWFT = 1;
    localparam int FIFO_MODE_REG  = 0;

    // Pointer width for a power-of-two depth; never narrower than one bit
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Status flags, all registered from the next-cycle occupancy
    typedef struct packed {
        logic wfull;
        logic rempty_n;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // An empty FIFO is never full and always at or below the low threshold
    localparam fifo_status_t FIFO_STATUS_RESET = '{
        wfull:        1'b0,
        rempty_n:     1'b0,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATASIZE register array: synchronous write, asynchronous read.
// Storage is deliberately left out of reset.
module fifo_sync_ram
    import fifo_sync_fwft_pkg::*;
#(
    parameter int  DATASIZE = 40,
    parameter int  DEPTH    = 8,
    localparam int AW       = ptr_width(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [DATASIZE-1:0] rdata
);

    logic [DATASIZE-1:0] mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            // Each entry loads only when the write pointer selects it
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    // Combinational read so the head word can fall through
    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with selectable read mode (first-word-fall-through or
// registered read), occupancy count, almost-full/empty thresholds and
// sticky overflow/underflow flags. Full/empty are resolved by count only,
// so the pointers wrap freely with no spare entry.
module fifo_sync_fwft
    import fifo_sync_fwft_pkg::*;
#(
    parameter int  DATASIZE = 40,
    parameter int  DEPTH    = 8,
    parameter int  FWFT     = 1,
    parameter int  AF_LEVEL = DEPTH - 2,
    parameter int  AE_LEVEL = 2,
    localparam int AW       = ptr_width(DEPTH),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                winc,
    input  logic                rinc,
    input  logic                err_clr,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty_n,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [CW-1:0]       count,
    output logic                overflow,
    output logic                underflow
);

    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [CW-1:0]       count_q, count_d;
    fifo_status_t        status_q, status_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                wr_acc, rd_acc;
    logic [DATASIZE-1:0] ram_rdata;

    fifo_sync_ram #(
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    // Accept decisions, pointer/count update and next-cycle status flags
    always_comb begin
        // Acceptance uses the registered flags only, so a same-cycle read
        // never frees room for a write and vice versa
        wr_acc = winc && !status_q.wfull;
        rd_acc = rinc && status_q.rempty_n;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + AW'(1);
        end

        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);

        status_d              = FIFO_STATUS_RESET;
        status_d.wfull        = (count_d == CW'(DEPTH));
        status_d.rempty_n     = (count_d != '0);
        status_d.almost_full  = (count_d >= CW'(AF_LEVEL));
        status_d.almost_empty = (count_d <= CW'(AE_LEVEL));

        // A new error event takes priority over a simultaneous clear
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (winc && status_q.wfull) begin
            overflow_d = 1'b1;
        end
        if (rinc && !status_q.rempty_n) begin
            underflow_d = 1'b1;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            status_q    <= FIFO_STATUS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            status_q    <= status_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word shown directly; forced to zero while empty so the
            // output is deterministic out of reset
            assign rdata = status_q.rempty_n ? ram_rdata : '0;
        end else begin : g_reg
            logic [DATASIZE-1:0] rdata_q, rdata_d;

            // Load the head word on an accepted read, hold otherwise
            always_comb begin
                rdata_d = rdata_q;
                if (rd_acc) begin
                    rdata_d = ram_rdata;
                end
            end

            // Registered read-data output
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

    assign wfull        = status_q.wfull;
    assign rempty_n     = status_q.rempty_n;
    assign almost_full  = status_q.almost_full;
    assign almost_empty = status_q.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Scoreboard bench: one FWFT instance and one registered-read instance.
// Stimulus pushes expected read words into queues; monitors pop and
// compare whenever a DUT delivers a word. Status is checked directly.
module tb_fifo_sync_fwft;

    localparam int DW    = 40;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance signals
    logic [DW-1:0] f_wdata = '0;
    logic          f_winc = 1'b0, f_rinc = 1'b0, f_err_clr = 1'b0;
    logic [DW-1:0] f_rdata;
    logic          f_wfull, f_rempty_n, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] f_count;

    // Registered-read instance signals
    logic [DW-1:0] r_wdata = '0;
    logic          r_winc = 1'b0, r_rinc = 1'b0, r_err_clr = 1'b0;
    logic [DW-1:0] r_rdata;
    logic          r_wfull, r_rempty_n, r_af, r_ae, r_ovf, r_unf;
    logic [CW-1:0] r_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_r[$];

    fifo_sync_fwft #(.DATASIZE(DW), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_f (
        .clk(clk), .rst_n(rst_n), .wdata(f_wdata), .winc(f_winc), .rinc(f_rinc),
        .err_clr(f_err_clr), .rdata(f_rdata), .wfull(f_wfull), .rempty_n(f_rempty_n),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_sync_fwft #(.DATASIZE(DW), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_r (
        .clk(clk), .rst_n(rst_n), .wdata(r_wdata), .winc(r_winc), .rinc(r_rinc),
        .err_clr(r_err_clr), .rdata(r_rdata), .wfull(r_wfull), .rempty_n(r_rempty_n),
        .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
        .overflow(r_ovf), .underflow(r_unf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Full status check of the FWFT instance against a hand-chosen count
    task automatic chk_f(input string tag, input int cnt, input bit ovf, input bit unf);
        chk({tag, "_count"},    64'(f_count),    64'(cnt));
        chk({tag, "_wfull"},    64'(f_wfull),    64'(cnt == DEPTH));
        chk({tag, "_rempty_n"}, 64'(f_rempty_n), 64'(cnt != 0));
        chk({tag, "_afull"},    64'(f_af),       64'(cnt >= AF));
        chk({tag, "_aempty"},   64'(f_ae),       64'(cnt <= AE));
        chk({tag, "_overflow"}, 64'(f_ovf),      64'(ovf));
        chk({tag, "_underflow"},64'(f_unf),      64'(unf));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_f(input logic [DW-1:0] d, input bit accept);
        f_wdata = d;
        f_winc  = 1'b1;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic wr_r(input logic [DW-1:0] d);
        r_wdata = d;
        r_winc  = 1'b1;
        exp_r.push_back(d);
    endtask

    // FWFT monitor: the displayed word is consumed when rinc meets rempty_n
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && f_rinc && f_rempty_n) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL f_pop: got 0x%0h expected no word", f_rdata);
                end else begin
                    chk("f_rdata", 64'(f_rdata), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Registered-read monitor: data appears just after the accepting edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && r_rinc && r_rempty_n) begin
                @(posedge clk);
                #1;
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_pop: got 0x%0h expected no word", r_rdata);
                end else begin
                    chk("r_rdata", 64'(r_rdata), 64'(exp_r.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cycle();
        cycle();
        chk_f("reset", 0, 1'b0, 1'b0);
        chk("reset_rdata", 64'(f_rdata), 64'h0);
        chk("reset_r_rdata", 64'(r_rdata), 64'h0);
        rst_n = 1'b1;
        cycle();

        // Fill 0x01..0x08, then overflow with a 9th write
        for (int i = 1; i <= 8; i++) begin
            wr_f(DW'(i), 1'b1);
            cycle();
            chk_f($sformatf("fill%0d", i), i, 1'b0, 1'b0);
            if (i == 1) chk("fwft_latency", 64'(f_rdata), 64'h01);
        end
        wr_f(DW'(9), 1'b0);
        cycle();
        f_winc = 1'b0;
        chk_f("ovf", 8, 1'b1, 1'b0);

        // Drain 8 words, then underflow, then clear both flags
        f_rinc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk_f($sformatf("drain%0d", i), 8 - i, 1'b1, 1'b0);
        end
        cycle();
        f_rinc = 1'b0;
        chk_f("unf", 0, 1'b1, 1'b1);
        f_err_clr = 1'b1;
        cycle();
        f_err_clr = 1'b0;
        chk_f("errclr", 0, 1'b0, 1'b0);

        // Full FIFO with read and write together: read wins, write dropped
        for (int i = 0; i < 8; i++) begin
            wr_f(DW'(8'h10 + i), 1'b1);
            cycle();
        end
        wr_f(DW'(8'h99), 1'b0);
        f_rinc = 1'b1;
        cycle();
        f_winc = 1'b0;
        chk_f("full_rw", 7, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle();
        f_rinc = 1'b0;
        f_err_clr = 1'b1;
        cycle();
        f_err_clr = 1'b0;
        chk_f("full_rw_drained", 0, 1'b0, 1'b0);

        // Half-full streaming across pointer wrap
        for (int i = 0; i < 4; i++) begin
            wr_f(DW'(8'h20 + i), 1'b1);
            cycle();
        end
        f_rinc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_f(DW'(8'h24 + i), 1'b1);
            cycle();
            chk("stream_count", 64'(f_count), 64'd4);
        end
        f_winc = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        f_rinc = 1'b0;
        chk_f("stream_done", 0, 1'b0, 1'b0);

        // Overflow event coinciding with err_clr keeps the flag set
        for (int i = 0; i < 8; i++) begin
            wr_f(DW'(8'h30 + i), 1'b1);
            cycle();
        end
        wr_f(DW'(8'h3f), 1'b0);
        cycle();
        chk("ovf_set", 64'(f_ovf), 64'd1);
        f_err_clr = 1'b1;
        cycle();
        chk("ovf_set_wins", 64'(f_ovf), 64'd1);
        f_winc = 1'b0;
        cycle();
        f_err_clr = 1'b0;
        chk_f("ovf_cleared", 8, 1'b0, 1'b0);

        // Registered-read mode: 0xAA then 0xBB, held afterwards
        wr_r(DW'(8'hAA));
        cycle();
        wr_r(DW'(8'hBB));
        cycle();
        r_winc = 1'b0;
        chk("reg_no_read_yet", 64'(r_rdata), 64'h0);
        chk("reg_count", 64'(r_count), 64'd2);
        r_rinc = 1'b1;
        cycle();
        cycle();
        r_rinc = 1'b0;
        cycle();
        cycle();
        chk("reg_hold", 64'(r_rdata), 64'hBB);
        chk("reg_empty", 64'(r_rempty_n), 64'd0);

        // Leave 5 words queued, then reset asynchronously mid-cycle
        f_rinc = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        f_rinc = 1'b0;
        chk("pre_reset_count", 64'(f_count), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_f("async_reset", 0, 1'b0, 1'b0);
        chk("async_reset_rdata", 64'(f_rdata), 64'h0);
        chk("async_reset_r_rdata", 64'(r_rdata), 64'h0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        cycle();
        wr_f(DW'(8'h55), 1'b1);
        cycle();
        f_winc = 1'b0;
        chk("post_reset_head", 64'(f_rdata), 64'h55);
        chk("post_reset_count", 64'(f_count), 64'd1);
        f_rinc = 1'b1;
        cycle();
        f_rinc = 1'b0;
        chk_f("post_reset_drain", 0, 1'b0, 1'b0);
        cycle();

        chk("f_scoreboard_left", 64'(exp_q.size()), 64'd0);
        chk("r_scoreboard_left", 64'(exp_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
